// File: rtl/ac97_codec_bfm_if.sv
// AC'97 serial link between controller (master) and codec model (slave).
// The codec owns bit_clk and sdata_in; the controller owns sync and sdata_out.
interface ac97_codec_bfm_if;
  logic bit_clk;
  logic sync;
  logic sdata_out;
  logic sdata_in;

  modport master (input bit_clk, input sdata_in, output sync, output sdata_out);
  modport slave  (output bit_clk, output sdata_in, input sync, input sdata_out);
endinterface

// File: rtl/ac97_codec_bfm.sv
// Synthesizable AC'97 codec model: bit_clk generation, SDATA_OUT frame capture,
// PCM slot latching and a 64x16 codec register file read back on SDATA_IN.
//
// state   | meaning
// ST_WAIT | start delay after reset; bit_clk held low
// ST_RUN  | bit_clk toggles every clk
module ac97_codec_bfm #(
  parameter int CLK_START_DELAY = 16,
  parameter int READY_FRAMES    = 2,
  parameter int PCM_WIDTH       = 20
) (
  input  logic                 clk,
  input  logic                 reset_b,
  ac97_codec_bfm_if.slave      link,
  output logic [15:0]          slot_0,
  output logic [PCM_WIDTH-1:0] slot_1,
  output logic [PCM_WIDTH-1:0] slot_2,
  output logic [PCM_WIDTH-1:0] slot_3,
  output logic [PCM_WIDTH-1:0] slot_4,
  output logic                 frame_strobe,
  output logic [15:0]          frame_count,
  output logic                 codec_ready,
  output logic                 sync_error
);

  localparam int DLY_W = $clog2(CLK_START_DELAY + 2);

  typedef enum logic {ST_WAIT, ST_RUN} state_t;

  state_t               state, state_nxt;
  logic [DLY_W-1:0]     dly_cnt, dly_cnt_nxt;
  logic                 toggle, rise, fall;
  logic                 bit_clk_q, sdata_in_q;

  logic                 sync_prev, sync_rise, seen_rise;
  logic [4:0]           hi_cnt;
  logic [7:0]           bit_cnt, cur_bit, nxt_bit;
  logic [PCM_WIDTH-1:0] sh, sh_nxt;
  logic [15:0]          tag_q;
  logic [PCM_WIDTH-1:0] s1_q, s2_q, s3_q, s4_q;
  logic                 frame_end, rd_req, wr_req;
  logic [5:0]           reg_idx;

  logic                 rd_pending;
  logic [6:0]           rd_addr;
  logic [15:0]          rd_data;
  logic [15:0]          regs [64];

  logic [55:0]          tx_vec;
  logic [5:0]           tx_idx;
  logic                 tx_bit;

  function automatic logic [15:0] reg_reset(input int idx);
    case (idx)
      6'h13:   return 16'h000F;
      6'h3E:   return 16'h4144;
      6'h3F:   return 16'h5370;
      default: return 16'h0000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state   <= ST_WAIT;
      dly_cnt <= DLY_W'(CLK_START_DELAY);
    end else begin
      state   <= state_nxt;
      dly_cnt <= dly_cnt_nxt;
    end
  end

  // The edge on which the delay expires already produces the first rise.
  always_comb begin
    state_nxt   = state;
    dly_cnt_nxt = dly_cnt;
    toggle      = 1'b0;
    case (state)
      ST_WAIT: begin
        if (dly_cnt == '0) begin
          state_nxt = ST_RUN;
          toggle    = 1'b1;
        end else begin
          dly_cnt_nxt = dly_cnt - 1'b1;
        end
      end
      ST_RUN:  toggle = 1'b1;
      default: state_nxt = ST_WAIT;
    endcase
  end

  assign rise = toggle & ~bit_clk_q;
  assign fall = toggle & bit_clk_q;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)    bit_clk_q <= 1'b0;
    else if (toggle) bit_clk_q <= ~bit_clk_q;
  end

  assign link.bit_clk  = bit_clk_q;
  assign link.sdata_in = sdata_in_q;

  always_comb begin
    sync_rise = link.sync & ~sync_prev;
    cur_bit   = sync_rise ? 8'd0 : bit_cnt + 8'd1;
    sh_nxt    = {sh[PCM_WIDTH-2:0], link.sdata_out};
    frame_end = fall & (cur_bit == 8'd255);
    reg_idx   = s1_q[18:13];
    rd_req    = tag_q[15] & tag_q[14] & s1_q[19];
    wr_req    = tag_q[15] & tag_q[14] & tag_q[13] & ~s1_q[19] & (reg_idx < 6'h3E);
  end

  // bit_cnt idles at 255 so an unsynchronised first bit lands on 0.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      sync_prev  <= 1'b0;
      bit_cnt    <= 8'hFF;
      sh         <= '0;
      tag_q      <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      s4_q       <= '0;
      hi_cnt     <= '0;
      seen_rise  <= 1'b0;
      sync_error <= 1'b0;
    end else if (fall) begin
      sync_prev <= link.sync;
      bit_cnt   <= cur_bit;
      sh        <= sh_nxt;
      case (cur_bit)
        8'd15:   tag_q <= sh_nxt[15:0];
        8'd35:   s1_q  <= sh_nxt;
        8'd55:   s2_q  <= sh_nxt;
        8'd75:   s3_q  <= sh_nxt;
        8'd95:   s4_q  <= sh_nxt;
        default: ;
      endcase
      if (link.sync) begin
        if (!sync_prev) begin
          hi_cnt    <= 5'd1;
          seen_rise <= 1'b1;
          if (seen_rise && bit_cnt != 8'd255) sync_error <= 1'b1;
        end else if (hi_cnt == 5'd16) begin
          sync_error <= 1'b1;
        end else begin
          hi_cnt <= hi_cnt + 5'd1;
        end
      end else if (sync_prev && hi_cnt != 5'd16) begin
        sync_error <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      slot_0       <= '0;
      slot_1       <= '0;
      slot_2       <= '0;
      slot_3       <= '0;
      slot_4       <= '0;
      frame_count  <= '0;
      codec_ready  <= 1'b0;
      frame_strobe <= 1'b0;
      rd_pending   <= 1'b0;
      rd_addr      <= '0;
      rd_data      <= '0;
    end else begin
      frame_strobe <= frame_end;
      if (frame_end) begin
        slot_0 <= tag_q;
        if (tag_q[15] & tag_q[14]) slot_1 <= s1_q;
        if (tag_q[15] & tag_q[13]) slot_2 <= s2_q;
        if (tag_q[15] & tag_q[12]) slot_3 <= s3_q;
        if (tag_q[15] & tag_q[11]) slot_4 <= s4_q;
        frame_count <= frame_count + 16'd1;
        if (frame_count + 16'd1 == 16'(READY_FRAMES)) codec_ready <= 1'b1;
        // A read response lives for exactly the one frame after the request.
        rd_pending <= rd_req;
        if (rd_req) begin
          rd_addr <= s1_q[18:12];
          rd_data <= regs[reg_idx];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < 64; i++) regs[i] <= reg_reset(i);
    end else if (frame_end && wr_req) begin
      regs[reg_idx] <= s2_q[19:4];
    end
  end

  // Each rise drives the bit the controller will sample at the following fall.
  always_comb begin
    nxt_bit = bit_cnt + 8'd1;
    tx_vec  = {codec_ready, rd_pending, rd_pending, 13'd0,
               rd_pending ? {1'b0, rd_addr, 12'd0} : 20'd0,
               rd_pending ? {rd_data, 4'd0}        : 20'd0};
    tx_idx  = 6'(8'd55 - nxt_bit);
    tx_bit  = (nxt_bit < 8'd56) ? tx_vec[tx_idx] : 1'b0;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)  sdata_in_q <= 1'b0;
    else if (rise) sdata_in_q <= tx_bit;
  end

endmodule

// File: tb/tb_ac97_codec_bfm.sv
// Directed bench acting as the AC'97 controller: drives frames on the rising
// bit_clk, captures sdata_in, and compares against hand-computed values.
module tb_ac97_codec_bfm;
  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic [15:0] slot_0;
  logic [19:0] slot_1, slot_2, slot_3, slot_4;
  logic        frame_strobe;
  logic [15:0] frame_count;
  logic        codec_ready, sync_error;

  int          checks = 0;
  int          passed = 0;
  int          strobe_cnt = 0;
  logic [15:0] cap_tag;
  logic [19:0] cap_s1, cap_s2;

  always #5 clk = ~clk;

  ac97_codec_bfm_if link ();

  ac97_codec_bfm #(.CLK_START_DELAY(16), .READY_FRAMES(2), .PCM_WIDTH(20)) dut (
    .clk          (clk),
    .reset_b      (reset_b),
    .link         (link),
    .slot_0       (slot_0),
    .slot_1       (slot_1),
    .slot_2       (slot_2),
    .slot_3       (slot_3),
    .slot_4       (slot_4),
    .frame_strobe (frame_strobe),
    .frame_count  (frame_count),
    .codec_ready  (codec_ready),
    .sync_error   (sync_error)
  );

  always @(negedge clk) if (frame_strobe === 1'b1) strobe_cnt++;

  task automatic wait_rise();
    for (int n = 0; n < 64; n++) begin
      @(posedge clk);
      #1;
      if (link.bit_clk === 1'b1) return;
    end
    checks++;
    $display("FAIL bit_clk_timeout no rise within 64 clks, bit_clk=%b", link.bit_clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  endtask

  task automatic send_frame(input logic [15:0] tag, input logic [19:0] s1, input logic [19:0] s2,
                            input logic [19:0] s3, input logic [19:0] s4,
                            input int sync_len, input int nbits);
    logic [95:0] v;
    v = {tag, s1, s2, s3, s4};
    cap_tag = '0;
    cap_s1  = '0;
    cap_s2  = '0;
    for (int i = 0; i < nbits; i++) begin
      wait_rise();
      link.sync      = (i < sync_len);
      link.sdata_out = v[95];
      v = v << 1;
      if (i < 16)      cap_tag = {cap_tag[14:0], link.sdata_in};
      else if (i < 36) cap_s1  = {cap_s1[18:0], link.sdata_in};
      else if (i < 56) cap_s2  = {cap_s2[18:0], link.sdata_in};
    end
  endtask

  task automatic end_frame();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_b        = 1'b0;
    link.sync      = 1'b0;
    link.sdata_out = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset_b = 1'b1;
  endtask

  task automatic test_reset();
    reset_b        = 1'b0;
    link.sync      = 1'b0;
    link.sdata_out = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (link.bit_clk !== 1'b0) $display("FAIL rst_bit_clk got %b want 0", link.bit_clk); else passed++;
    checks++; if (link.sdata_in !== 1'b0) $display("FAIL rst_sdata_in got %b want 0", link.sdata_in); else passed++;
    checks++; if (slot_3 !== 20'h0) $display("FAIL rst_slot_3 got %h want 00000", slot_3); else passed++;
    checks++; if (frame_count !== 16'h0) $display("FAIL rst_frame_count got %h want 0000", frame_count); else passed++;
    checks++; if ({codec_ready, sync_error} !== 2'b00) $display("FAIL rst_flags got %b want 00", {codec_ready, sync_error}); else passed++;
    @(negedge clk);
    reset_b = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    checks++; if (link.bit_clk !== 1'b0) $display("FAIL start_delay_low got %b want 0", link.bit_clk); else passed++;
    @(posedge clk); #1;
    checks++; if (link.bit_clk !== 1'b1) $display("FAIL first_rise got %b want 1", link.bit_clk); else passed++;
    @(posedge clk); #1;
    checks++; if (link.bit_clk !== 1'b0) $display("FAIL period_fall got %b want 0", link.bit_clk); else passed++;
    @(posedge clk); #1;
    checks++; if (link.bit_clk !== 1'b1) $display("FAIL period_rise got %b want 1", link.bit_clk); else passed++;
  endtask

  task automatic test_pcm_single();
    int s0;
    do_reset();
    s0 = strobe_cnt;
    send_frame(16'h9800, 20'h0, 20'h0, 20'hFFFCE, 20'hFFFCE, 16, 256);
    end_frame();
    checks++; if (slot_3 !== 20'hFFFCE) $display("FAIL pcm_slot_3 got %h want fffce", slot_3); else passed++;
    checks++; if (slot_4 !== 20'hFFFCE) $display("FAIL pcm_slot_4 got %h want fffce", slot_4); else passed++;
    checks++; if (slot_0 !== 16'h9800) $display("FAIL pcm_slot_0 got %h want 9800", slot_0); else passed++;
    checks++; if (slot_1 !== 20'h0) $display("FAIL pcm_slot_1_hold got %h want 00000", slot_1); else passed++;
    checks++; if (frame_strobe !== 1'b1) $display("FAIL pcm_strobe got %b want 1", frame_strobe); else passed++;
    checks++; if (frame_count !== 16'd1) $display("FAIL pcm_frame_count got %0d want 1", frame_count); else passed++;
    checks++; if (codec_ready !== 1'b0) $display("FAIL pcm_not_ready got %b want 0", codec_ready); else passed++;
    @(negedge clk); #1;
    checks++; if (strobe_cnt !== s0 + 1) $display("FAIL pcm_strobe_pulses got %0d want %0d", strobe_cnt - s0, 1); else passed++;
  endtask

  task automatic test_stream();
    logic [19:0] smp;
    for (int v = -49; v <= 50; v++) begin
      smp = 20'(v);
      send_frame(16'h9800, 20'h0, 20'h0, smp, smp, 16, 256);
      end_frame();
      checks++; if (slot_3 !== smp) $display("FAIL stream_slot_3 got %h want %h", slot_3, smp); else passed++;
    end
    for (int k = 0; k < 10; k++) begin
      send_frame(16'h9800, 20'h0, 20'h0, 20'h00032, 20'h00032, 16, 256);
      end_frame();
      checks++; if (slot_3 !== 20'h00032) $display("FAIL hold_slot_3 got %h want 00032", slot_3); else passed++;
    end
    checks++; if (sync_error !== 1'b0) $display("FAIL stream_sync_error got %b want 0", sync_error); else passed++;
    checks++; if (frame_count !== 16'd111) $display("FAIL stream_frame_count got %0d want 111", frame_count); else passed++;
    checks++; if (codec_ready !== 1'b1) $display("FAIL stream_ready got %b want 1", codec_ready); else passed++;
  endtask

  task automatic test_tag_invalid();
    send_frame(16'h8000, 20'h0, 20'h0, 20'h12345, 20'h12345, 16, 256);
    end_frame();
    checks++; if (slot_3 !== 20'h00032) $display("FAIL invalid_slot_3 got %h want 00032", slot_3); else passed++;
    checks++; if (slot_4 !== 20'h00032) $display("FAIL invalid_slot_4 got %h want 00032", slot_4); else passed++;
    checks++; if (slot_0 !== 16'h8000) $display("FAIL invalid_slot_0 got %h want 8000", slot_0); else passed++;
  endtask

  task automatic test_regfile();
    send_frame(16'hE000, 20'h02000, 20'h08080, 20'h0, 20'h0, 16, 256);
    end_frame();
    checks++; if (slot_1 !== 20'h02000) $display("FAIL wr_slot_1 got %h want 02000", slot_1); else passed++;
    checks++; if (slot_2 !== 20'h08080) $display("FAIL wr_slot_2 got %h want 08080", slot_2); else passed++;
    send_frame(16'hC000, 20'h82000, 20'h0, 20'h0, 20'h0, 16, 256);
    end_frame();
    send_frame(16'hC000, 20'hFC000, 20'h0, 20'h0, 20'h0, 16, 256);
    checks++; if (cap_tag !== 16'hE000) $display("FAIL rd02_tag got %h want e000", cap_tag); else passed++;
    checks++; if (cap_s1 !== 20'h02000) $display("FAIL rd02_slot_1 got %h want 02000", cap_s1); else passed++;
    checks++; if (cap_s2 !== 20'h08080) $display("FAIL rd02_slot_2 got %h want 08080", cap_s2); else passed++;
    end_frame();
    send_frame(16'hE000, 20'h7E000, 20'h12340, 20'h0, 20'h0, 16, 256);
    checks++; if (cap_s1 !== 20'h7C000) $display("FAIL rd7c_slot_1 got %h want 7c000", cap_s1); else passed++;
    checks++; if (cap_s2 !== 20'h41440) $display("FAIL rd7c_slot_2 got %h want 41440", cap_s2); else passed++;
    end_frame();
    send_frame(16'hC000, 20'hFE000, 20'h0, 20'h0, 20'h0, 16, 256);
    checks++; if (cap_tag !== 16'h8000) $display("FAIL idle_tag got %h want 8000", cap_tag); else passed++;
    checks++; if (cap_s2 !== 20'h0) $display("FAIL idle_slot_2 got %h want 00000", cap_s2); else passed++;
    end_frame();
    send_frame(16'h8000, 20'h0, 20'h0, 20'h0, 20'h0, 16, 256);
    checks++; if (cap_s1 !== 20'h7E000) $display("FAIL rd7e_slot_1 got %h want 7e000", cap_s1); else passed++;
    checks++; if (cap_s2 !== 20'h53700) $display("FAIL rd7e_ro_slot_2 got %h want 53700", cap_s2); else passed++;
    end_frame();
  endtask

  task automatic test_sync_error();
    checks++; if (sync_error !== 1'b0) $display("FAIL pre_sync_error got %b want 0", sync_error); else passed++;
    send_frame(16'h8000, 20'h0, 20'h0, 20'h0, 20'h0, 17, 256);
    end_frame();
    checks++; if (sync_error !== 1'b1) $display("FAIL sync17_error got %b want 1", sync_error); else passed++;
    send_frame(16'h8000, 20'h0, 20'h0, 20'h0, 20'h0, 16, 256);
    end_frame();
    checks++; if (sync_error !== 1'b1) $display("FAIL sync_sticky got %b want 1", sync_error); else passed++;
  endtask

  task automatic test_reset_midframe();
    send_frame(16'h9800, 20'h0, 20'h0, 20'h11111, 20'h22222, 16, 120);
    #2;
    reset_b = 1'b0;
    #1;
    checks++; if ({link.bit_clk, link.sdata_in, frame_strobe} !== 3'b000) $display("FAIL mid_rst_bits got %b want 000", {link.bit_clk, link.sdata_in, frame_strobe}); else passed++;
    checks++; if ({slot_0, slot_1, slot_2, slot_3, slot_4} !== 96'h0) $display("FAIL mid_rst_slots got %h want 0", {slot_0, slot_1, slot_2, slot_3, slot_4}); else passed++;
    checks++; if ({frame_count, codec_ready, sync_error} !== 18'h0) $display("FAIL mid_rst_status got %h want 0", {frame_count, codec_ready, sync_error}); else passed++;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset_b = 1'b1;
    send_frame(16'hC000, 20'h82000, 20'h0, 20'h0, 20'h0, 16, 256);
    end_frame();
    checks++; if (frame_count !== 16'd1) $display("FAIL post_rst_count got %0d want 1", frame_count); else passed++;
    checks++; if (slot_3 !== 20'h0) $display("FAIL post_rst_slot_3 got %h want 00000", slot_3); else passed++;
    send_frame(16'hC000, 20'hA6000, 20'h0, 20'h0, 20'h0, 16, 256);
    checks++; if (cap_tag !== 16'h6000) $display("FAIL post_rst_tag got %h want 6000", cap_tag); else passed++;
    checks++; if (cap_s2 !== 20'h0) $display("FAIL post_rst_reg02 got %h want 00000", cap_s2); else passed++;
    end_frame();
    send_frame(16'h8000, 20'h0, 20'h0, 20'h0, 20'h0, 16, 256);
    checks++; if (cap_tag !== 16'hE000) $display("FAIL rd26_tag got %h want e000", cap_tag); else passed++;
    checks++; if (cap_s1 !== 20'h26000) $display("FAIL rd26_slot_1 got %h want 26000", cap_s1); else passed++;
    checks++; if (cap_s2 !== 20'h000F0) $display("FAIL rd26_slot_2 got %h want 000f0", cap_s2); else passed++;
    end_frame();
    checks++; if (sync_error !== 1'b0) $display("FAIL post_rst_sync_error got %b want 0", sync_error); else passed++;
  endtask

  initial begin
    link.sync      = 1'b0;
    link.sdata_out = 1'b0;
    test_reset();
    test_pcm_single();
    test_stream();
    test_tag_invalid();
    test_regfile();
    test_sync_error();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
